// File: rtl/vend_pkg.sv
// vend_pkg -- shared types and constants for the change dispenser.
//
// Contents:
//   state_t    dispenser FSM states
//   UNIT_RS5   value of one Rs5 coin, in Rs5 units
//   UNIT_RS10  value of one Rs10 coin, in Rs5 units
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    PULSE,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  localparam logic [3:0] UNIT_RS5  = 4'd1;
  localparam logic [3:0] UNIT_RS10 = 4'd2;

endpackage

// File: rtl/dispense_timer.sv
// dispense_timer -- down-counter shared by the motor pulse and the ack timeout.
//
// Ports:
//   clk      in   system clock (rising edge)
//   reset    in   synchronous, active-high reset; clears the count
//   start    in   load the counter with 'load' at this edge
//   load     in   W  number of cycles to run
//   expired  out  high during the last counted cycle, so the owner can act
//                 on the same edge at which the count runs out
module dispense_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= load;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A load of N gives N cycles before the owner's transition edge.
  assign expired = (count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser -- pays out change from an Rs10 and an Rs5 coin hopper.
//
// Ports:
//   clk                      in   system clock (rising edge)
//   reset                    in   synchronous, active-high reset
//   chg_valid                in   change request valid
//   chg_units                in   4  change owed in Rs5 units
//   chg_ready                out  dispenser idle and ready for a request
//   hop10_pulse, hop5_pulse  out  hopper motor drive
//   hop10_ack, hop5_ack      in   coin-drop sensor pulses
//   hop10_empty, hop5_empty  in   hopper-empty levels
//   fault_clr                in   clears a latched fault
//   done                     out  one-cycle pulse when the full amount is paid
//   fault                    out  latched fault level
//   paid_units               out  4  Rs5 units paid in the current/last request
//
// Rs10 coins are preferred; with the Rs10 hopper empty the amount is paid
// with Rs5 coins instead. Each coin is one motor pulse of PULSE_CYCLES,
// followed by up to ACK_TIMEOUT cycles waiting for the drop sensor.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chg_valid,
  input  logic [3:0] chg_units,
  output logic       chg_ready,
  output logic       hop10_pulse,
  output logic       hop5_pulse,
  input  logic       hop10_ack,
  input  logic       hop5_ack,
  input  logic       hop10_empty,
  input  logic       hop5_empty,
  input  logic       fault_clr,
  output logic       done,
  output logic       fault,
  output logic [3:0] paid_units
);

  state_t     state;
  logic [3:0] remaining;
  logic       sel10;      // 1: Rs10 hopper selected, 0: Rs5 hopper
  logic       ack10_q;
  logic       ack5_q;

  logic       can10;
  logic       can5;
  logic       sel_go;
  logic       ack_hit;
  logic       pulse_end;
  logic       timer_start;
  logic [7:0] timer_load;
  logic       expired;
  logic [3:0] coin;

  assign can10 = (remaining >= UNIT_RS10) && !hop10_empty;
  assign can5  = (remaining >= UNIT_RS5) && !hop5_empty;

  // SEL is about to start a motor pulse.
  assign sel_go = (state == SEL) && (remaining != 4'd0) && (can10 || can5);

  // Only the registered ack of the hopper actually being driven counts.
  assign ack_hit = ((state == PULSE) || (state == WAIT_ACK)) &&
                   (sel10 ? ack10_q : ack5_q);

  assign pulse_end = (state == PULSE) && expired && !ack_hit;

  // One timer serves both phases: loaded with the pulse length when a coin
  // is selected, reloaded with the timeout when the pulse finishes.
  assign timer_start = sel_go || pulse_end;
  assign timer_load  = sel_go ? 8'(PULSE_CYCLES) : 8'(ACK_TIMEOUT);

  assign coin = sel10 ? UNIT_RS10 : UNIT_RS5;

  dispense_timer #(
    .W(8)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (timer_start),
    .load   (timer_load),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= 4'd0;
      paid_units  <= 4'd0;
      sel10       <= 1'b0;
      chg_ready   <= 1'b1;
      hop10_pulse <= 1'b0;
      hop5_pulse  <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      ack10_q     <= 1'b0;
      ack5_q      <= 1'b0;
    end else begin
      ack10_q <= hop10_ack;
      ack5_q  <= hop5_ack;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          if (chg_valid) begin
            remaining  <= chg_units;
            paid_units <= 4'd0;
            chg_ready  <= 1'b0;
            state      <= SEL;
          end
        end

        SEL: begin
          if (remaining == 4'd0) begin
            state <= DONE;
          end else if (can10) begin
            sel10       <= 1'b1;
            hop10_pulse <= 1'b1;
            state       <= PULSE;
          end else if (can5) begin
            sel10      <= 1'b0;
            hop5_pulse <= 1'b1;
            state      <= PULSE;
          end else begin
            fault <= 1'b1;
            state <= FAULT;
          end
        end

        PULSE, WAIT_ACK: begin
          // A coin drop wins over a simultaneous pulse end or timeout.
          if (ack_hit) begin
            hop10_pulse <= 1'b0;
            hop5_pulse  <= 1'b0;
            remaining   <= remaining - coin;
            paid_units  <= paid_units + coin;
            state       <= SEL;
          end else if (state == PULSE) begin
            if (expired) begin
              hop10_pulse <= 1'b0;
              hop5_pulse  <= 1'b0;
              state       <= WAIT_ACK;
            end
          end else if (expired) begin
            fault <= 1'b1;
            state <= FAULT;
          end
        end

        DONE: begin
          // done is registered off the DONE state, so it appears the
          // cycle the dispenser is back in IDLE.
          done      <= 1'b1;
          chg_ready <= 1'b1;
          state     <= IDLE;
        end

        FAULT: begin
          if (fault_clr) begin
            fault     <= 1'b0;
            chg_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
